// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM macro between an instruction-fetch
// port (p0, read-only) and a data load/store port (p1).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   p0_req/addr           fetch request and byte address
//   p0_gnt                fetch granted this cycle (combinational)
//   p0_rvalid/rdata       fetch read data, one cycle after grant
//   p1_req/addr/web/wdata data request, byte address, byte write
//                         enables (active low, 4'b1111 = read), write data
//   p1_gnt                data port granted this cycle (combinational)
//   p1_rvalid/rdata       data read data, one cycle after a read grant
//   sram_cs/oe/web/a/di   SRAM pins, driven for the granted access
//   sram_do               SRAM read data, valid before the rising edge
//
// Arbitration is data-first with an anti-starvation counter on the fetch
// port (RR_MODE=0), or strict alternation between the two ports (RR_MODE=1).
module sram_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4,
    parameter int RR_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [31:0]       p0_addr,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic [31:0]       p1_addr,
    input  logic [3:0]        p1_web,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [3:0]        sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_di,
    input  logic [31:0]       sram_do
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       last_gnt;
    logic       p1_rd;
    logic       pick1;

    // Byte-offset and high address bits are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{p0_addr[31:ADDR_W+2], p0_addr[1:0],
                           p1_addr[31:ADDR_W+2], p1_addr[1:0]};

    assign p1_rd = (p1_web == 4'b1111);

    // pick1 only decides contention; a lone request always wins.
    always_comb begin
        pick1 = 1'b0;
        if (p1_req && !p0_req) begin
            pick1 = 1'b1;
        end else if (p1_req && p0_req) begin
            if (RR_MODE != 0) begin
                pick1 = (last_gnt == 1'b0);
            end else begin
                pick1 = (wait_cnt != MAX_W);
            end
        end
    end

    // No grant while in reset so the SRAM stays deselected.
    assign p0_gnt = !rst && p0_req && !pick1;
    assign p1_gnt = !rst && p1_req && pick1;

    always_comb begin
        sram_cs  = 1'b0;
        sram_oe  = 1'b0;
        sram_web = 4'b1111;
        sram_a   = '0;
        sram_di  = '0;
        if (p0_gnt) begin
            sram_cs = 1'b1;
            sram_oe = 1'b1;
            sram_a  = p0_addr[ADDR_W+1:2];
        end else if (p1_gnt) begin
            sram_cs  = 1'b1;
            sram_oe  = p1_rd;
            sram_web = p1_web;
            sram_a   = p1_addr[ADDR_W+1:2];
            sram_di  = p1_wdata;
        end
    end

    // SRAM runs on ~clk, so sram_do for a cycle-N access is already
    // settled at the rising edge that ends cycle N.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            last_gnt  <= 1'b1;
            p0_rvalid <= 1'b0;
            p0_rdata  <= 32'd0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= 32'd0;
        end else begin
            if (!p0_req || p0_gnt) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != MAX_W) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (p0_gnt) begin
                last_gnt <= 1'b0;
            end else if (p1_gnt) begin
                last_gnt <= 1'b1;
            end
            p0_rvalid <= p0_gnt;
            if (p0_gnt) begin
                p0_rdata <= sram_do;
            end
            p1_rvalid <= p1_gnt && p1_rd;
            if (p1_gnt && p1_rd) begin
                p1_rdata <= sram_do;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench for sram_port_arbiter with a
// behavioural SRAM clocked on the falling edge.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req;
    logic [31:0] p1_addr;
    logic [3:0]  p1_web;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        sram_cs;
    logic        sram_oe;
    logic [3:0]  sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do;

    logic        rr_rst;
    logic        rr_p0_req;
    logic        rr_p1_req;
    logic        rr_p0_gnt;
    logic        rr_p0_rvalid;
    logic [31:0] rr_p0_rdata;
    logic        rr_p1_gnt;
    logic        rr_p1_rvalid;
    logic [31:0] rr_p1_rdata;
    logic        rr_cs;
    logic        rr_oe;
    logic [3:0]  rr_web;
    logic [13:0] rr_a;
    logic [31:0] rr_di;
    logic [31:0] rr_do;
    logic [31:0] rr_addr;
    logic [3:0]  rr_p1_web;
    logic [31:0] rr_wdata;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(14), .MAX_WAIT(4), .RR_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_web(p1_web),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    sram_port_arbiter #(.ADDR_W(14), .MAX_WAIT(4), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rr_rst),
        .p0_req(rr_p0_req), .p0_addr(rr_addr), .p0_gnt(rr_p0_gnt),
        .p0_rvalid(rr_p0_rvalid), .p0_rdata(rr_p0_rdata),
        .p1_req(rr_p1_req), .p1_addr(rr_addr), .p1_web(rr_p1_web),
        .p1_wdata(rr_wdata), .p1_gnt(rr_p1_gnt),
        .p1_rvalid(rr_p1_rvalid), .p1_rdata(rr_p1_rdata),
        .sram_cs(rr_cs), .sram_oe(rr_oe), .sram_web(rr_web),
        .sram_a(rr_a), .sram_di(rr_di), .sram_do(rr_do)
    );

    // Behavioural SRAM: accesses take effect on the falling edge.
    always @(negedge clk) begin
        if (sram_cs) begin
            if (sram_oe) sram_do <= mem[sram_a[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (!sram_web[b]) mem[sram_a[7:0]][8*b +: 8] <= sram_di[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Return to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_rr0 [0:5];
    logic [1:0] exp_rr1 [0:3];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        // {p1_gnt, p0_gnt}
        exp_rr0 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        exp_rr1 = '{2'b01, 2'b10, 2'b01, 2'b10};

        sram_do   = 32'd0;
        rst       = 1'b1;
        p0_req    = 1'b0;
        p0_addr   = 32'd0;
        p1_req    = 1'b0;
        p1_addr   = 32'd0;
        p1_web    = 4'hF;
        p1_wdata  = 32'd0;
        rr_rst    = 1'b1;
        rr_p0_req = 1'b0;
        rr_p1_req = 1'b0;
        rr_do     = 32'd0;
        rr_addr   = 32'd0;
        rr_p1_web = 4'hF;
        rr_wdata  = 32'd0;

        tick();
        tick();
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        check("rst_p1_rdata", p1_rdata, 32'd0);
        check("rst_cs", 32'(sram_cs), 32'd0);
        check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        check("rst_last_gnt", 32'(dut.last_gnt), 32'd1);

        // Fetch read at 0x10 -> word 4.
        rst     = 1'b0;
        p0_req  = 1'b1;
        p0_addr = 32'h10;
        #1;
        check("t1_p0_gnt", 32'(p0_gnt), 32'd1);
        check("t1_p1_gnt", 32'(p1_gnt), 32'd0);
        check("t1_sram_a", 32'(sram_a), 32'd4);
        check("t1_cs", 32'(sram_cs), 32'd1);
        check("t1_oe", 32'(sram_oe), 32'd1);
        check("t1_web", 32'(sram_web), 32'hF);
        tick();
        p0_req = 1'b0;
        check("t1_rvalid", 32'(p0_rvalid), 32'd1);
        check("t1_rdata", p0_rdata, 32'hA500_0004);
        tick();
        check("t1_rvalid_drop", 32'(p0_rvalid), 32'd0);
        check("t1_rdata_hold", p0_rdata, 32'hA500_0004);

        // Partial write of the low half, then read back.
        p1_req   = 1'b1;
        p1_addr  = 32'h20;
        p1_web   = 4'b1100;
        p1_wdata = 32'hDEAD_BEEF;
        #1;
        check("t2_w_gnt", 32'(p1_gnt), 32'd1);
        check("t2_w_web", 32'(sram_web), 32'hC);
        check("t2_w_oe", 32'(sram_oe), 32'd0);
        check("t2_w_a", 32'(sram_a), 32'd8);
        check("t2_w_di", sram_di, 32'hDEAD_BEEF);
        tick();
        p1_web = 4'hF;
        check("t2_w_no_rvalid", 32'(p1_rvalid), 32'd0);
        check("t2_w_rdata_hold", p1_rdata, 32'd0);
        #1;
        check("t2_r_gnt", 32'(p1_gnt), 32'd1);
        check("t2_r_oe", 32'(sram_oe), 32'd1);
        tick();
        p1_req = 1'b0;
        check("t2_r_rvalid", 32'(p1_rvalid), 32'd1);
        check("t2_r_rdata", p1_rdata, 32'hA500_BEEF);

        // Idle cycles: SRAM deselected, read data held.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_cs", 32'(sram_cs), 32'd0);
            check("t6_oe", 32'(sram_oe), 32'd0);
            check("t6_web", 32'(sram_web), 32'hF);
            check("t6_rvalids", 32'({p1_rvalid, p0_rvalid}), 32'd0);
            check("t6_p0_rdata", p0_rdata, 32'hA500_0004);
            check("t6_p1_rdata", p1_rdata, 32'hA500_BEEF);
        end

        // Contention in data-first mode: p0 forced through after 4 denials.
        p0_req  = 1'b1;
        p0_addr = 32'h10;
        p1_req  = 1'b1;
        p1_addr = 32'h24;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("t3_gnt_c%0d", i), 32'({p1_gnt, p0_gnt}),
                  32'(exp_rr0[i]));
            tick();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
        tick();

        // Reset right after a granted fetch read.
        p0_req = 1'b1;
        #1;
        check("t5_p0_gnt", 32'(p0_gnt), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("t5_cs_in_rst", 32'(sram_cs), 32'd0);
        check("t5_gnt_in_rst", 32'(p0_gnt), 32'd0);
        tick();
        check("t5_rvalid", 32'(p0_rvalid), 32'd0);
        check("t5_rdata", p0_rdata, 32'd0);
        check("t5_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        check("t5_last_gnt", 32'(dut.last_gnt), 32'd1);
        rst    = 1'b0;
        p0_req = 1'b0;

        // Round-robin instance: both requests on from reset.
        rr_p0_req = 1'b1;
        rr_p1_req = 1'b1;
        tick();
        rr_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4_rr_c%0d", i), 32'({rr_p1_gnt, rr_p0_gnt}),
                  32'(exp_rr1[i]));
            tick();
        end
        rr_p0_req = 1'b0;
        rr_p1_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
